// File: rtl/outbox_pkg.sv
// outbox_pkg: shared HRM datapath width, R-mux select encodings and the outbox debug macro
`define OUTBOX_DEBUG(v) $display("%t DEBUG OUTBOX=%h", $time, v)
package outbox_pkg;
  localparam int DATA_W = 8;
  typedef enum logic [1:0] {
    RSEL_HOLD  = 2'd0,
    RSEL_INBOX = 2'd1,
    RSEL_ALU   = 2'd2,
    RSEL_MEM   = 2'd3
  } rsel_e;
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: simple dual-port array, synchronous write, asynchronous read
module fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [DATA_W-1:0]     rdata
);
  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/outbox.sv
// outbox: output FIFO fed from register R, drained via valid/ready, with sticky overflow
module outbox
  import outbox_pkg::*;
#(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     iR,
  input  logic                  wO,
  output logic                  oFull,
  output logic                  oEmpty,
  output logic [DATA_W-1:0]     oData,
  output logic                  oValid,
  input  logic                  iRd,
  output logic [DEPTH_LOG2:0]   oCount,
  output logic                  oOverflow
);
  localparam int CW = DEPTH_LOG2 + 1;
  logic [DEPTH_LOG2-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic ovf, push, pop;
  assign oFull = cnt == CW'(1 << DEPTH_LOG2);
  assign oEmpty = cnt == '0;
  assign oValid = !oEmpty;
  assign oCount = cnt;
  assign oOverflow = ovf;
  assign pop = oValid && iRd;
  // a pop frees the head slot in the same edge, so a full buffer can still accept
  assign push = wO && (!oFull || pop);
  fifo_mem #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_mem (
    .clk(clk),
    .we(push && !rst),
    .waddr(wp),
    .wdata(iR),
    .raddr(rp),
    .rdata(oData)
  );
  always_ff @(posedge clk)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      wp <= push ? wp + DEPTH_LOG2'(1) : wp;
      rp <= pop ? rp + DEPTH_LOG2'(1) : rp;
      cnt <= (push && !pop) ? cnt + CW'(1) : (pop && !push) ? cnt - CW'(1) : cnt;
      ovf <= ovf || (wO && !push);
    end
`ifndef SYNTHESIS
  always @(posedge clk)
    if (!rst && push) `OUTBOX_DEBUG(iR);
`endif
endmodule

// File: tb/tb_outbox.sv
// tb_outbox: queue-model scoreboard plus directed literal checks for outbox
module tb_outbox;
  localparam int DEPTH = 8;
  logic clk = 1'b0, rst = 1'b1, wO = 1'b0, iRd = 1'b0;
  logic [7:0] iR = '0, oData;
  logic oFull, oEmpty, oValid, oOverflow;
  logic [3:0] oCount;
  int checks = 0, failures = 0;
  logic [7:0] q[$], drained[$];
  bit m_ovf = 1'b0, armed = 1'b0;

  outbox #(.DEPTH_LOG2(3)) dut (
    .clk(clk), .rst(rst), .iR(iR), .wO(wO), .oFull(oFull), .oEmpty(oEmpty),
    .oData(oData), .oValid(oValid), .iRd(iRd), .oCount(oCount), .oOverflow(oOverflow)
  );

  always #5 clk = ~clk;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  // behavioural model: occupancy is just the queue length
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_ovf = 1'b0;
      armed = 1'b1;
    end else begin
      bit p, f;
      p = q.size() > 0 && iRd;
      f = q.size() == DEPTH;
      if (p) drained.push_back(q.pop_front());
      if (wO && (!f || p)) q.push_back(iR);
      else if (wO) m_ovf = 1'b1;
    end
  end

  always @(negedge clk)
    if (armed) begin
      chk("count", 32'(oCount), q.size());
      chk("empty", 32'(oEmpty), 32'(q.size() == 0));
      chk("valid", 32'(oValid), 32'(q.size() != 0));
      chk("full", 32'(oFull), 32'(q.size() == DEPTH));
      chk("overflow", 32'(oOverflow), 32'(m_ovf));
      if (q.size() != 0) chk("data", 32'(oData), 32'(q[0]));
    end

  task automatic cyc(logic w, logic [7:0] d, logic r);
    wO = w; iR = d; iRd = r;
    @(posedge clk);
    #1;
    wO = 1'b0; iRd = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (oValid && n < 20) begin
      cyc(1'b0, 8'h00, 1'b1);
      n++;
    end
    chk("drain_bound", 32'(oValid), 32'd0);
  endtask

  initial begin
    logic [7:0] exp_wrap[11];
    exp_wrap = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h10, 8'h11, 8'h12};
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(1'b0, 8'h00, 1'b0);
    chk("rst_empty", 32'(oEmpty), 32'd1);
    chk("rst_valid", 32'(oValid), 32'd0);
    chk("rst_count", 32'(oCount), 32'd0);
    chk("rst_ovf", 32'(oOverflow), 32'd0);
    cyc(1'b1, 8'h2A, 1'b0);
    chk("single_valid", 32'(oValid), 32'd1);
    chk("single_data", 32'(oData), 32'h2A);
    chk("single_count", 32'(oCount), 32'd1);
    cyc(1'b0, 8'h00, 1'b1);
    chk("single_popped", 32'(oEmpty), 32'd1);
    drained.delete();
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'(i), 1'b0);
    chk("fill_full", 32'(oFull), 32'd1);
    chk("fill_count", 32'(oCount), 32'd8);
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'h10 + 8'(i), 1'b0);
    chk("refill_full", 32'(oFull), 32'd1);
    cyc(1'b1, 8'hFF, 1'b0);
    chk("ovf_set", 32'(oOverflow), 32'd1);
    chk("ovf_count", 32'(oCount), 32'd8);
    drain();
    chk("wrap_len", drained.size(), 32'd11);
    for (int i = 0; i < 11; i++)
      if (i < drained.size()) chk("wrap_order", 32'(drained[i]), 32'(exp_wrap[i]));
    chk("ovf_sticky", 32'(oOverflow), 32'd1);
    rst = 1'b1;
    cyc(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    chk("ovf_cleared", 32'(oOverflow), 32'd0);
    drained.delete();
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'h20 + 8'(i), 1'b0);
    cyc(1'b1, 8'h55, 1'b1);
    chk("fullpp_count", 32'(oCount), 32'd8);
    chk("fullpp_ovf", 32'(oOverflow), 32'd0);
    drain();
    chk("fullpp_len", drained.size(), 32'd9);
    if (drained.size() == 9) begin
      chk("fullpp_first", 32'(drained[1]), 32'h21);
      chk("fullpp_last", 32'(drained[8]), 32'h55);
    end
    cyc(1'b1, 8'h66, 1'b1);
    chk("emptypp_count", 32'(oCount), 32'd1);
    chk("emptypp_data", 32'(oData), 32'h66);
    drain();
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'h30 + 8'(i), 1'b0);
    chk("mid_count5", 32'(oCount), 32'd5);
    rst = 1'b1;
    cyc(1'b1, 8'h77, 1'b0);
    rst = 1'b0;
    chk("mid_rst_count", 32'(oCount), 32'd0);
    chk("mid_rst_empty", 32'(oEmpty), 32'd1);
    cyc(1'b0, 8'h00, 1'b0);
    chk("mid_rst_lost", 32'(oValid), 32'd0);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
